// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package inst_fetch_unit_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned INST_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  // 2-bit fetch controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_WAIT  = 2'b10
  } fetch_state_e;

  // Clears the two low bits so a redirect target is always word aligned
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_inst_buffer.sv
// One-entry valid/ready holding register between fetch and decode.
module inst_buffer
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter int unsigned     INST_WIDTH = INST_WIDTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [INST_WIDTH-1:0] NOP_VALUE = NOP_INST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_i,
  input  logic                  consume_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic [XLEN-1:0]       pc_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [XLEN-1:0]       inst_pc_o,
  output logic                  inst_valid_o
);

  logic [INST_WIDTH-1:0] inst_q;
  logic [XLEN-1:0]       instPc_q;
  logic                  valid_q;

  // Capture wins over consume so back-to-back fetches keep the slot full; data holds when drained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q   <= NOP_VALUE;
      instPc_q <= RESET_PC;
      valid_q  <= 1'b0;
    end else if (capture_i) begin
      inst_q   <= inst_i;
      instPc_q <= pc_i;
      valid_q  <= 1'b1;
    end else if (consume_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign inst_o       = inst_q;
  assign inst_pc_o    = instPc_q;
  assign inst_valid_o = valid_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection, fetch FSM and decode buffer.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter int unsigned     INST_WIDTH = INST_WIDTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic [XLEN-1:0]       inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  pc_sel,
  input  logic [XLEN-1:0]       alu_out
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] redirectTarget;
  logic            consume;
  logic            redirect;
  logic            slotFree;
  logic            capture;

  assign consume        = inst_valid & inst_ready;
  assign redirect       = consume & pc_sel;
  assign slotFree       = ~inst_valid | consume;
  assign capture        = imem_req & imem_ack;
  assign redirectTarget = alu_out & ~XLEN'(3);
  assign imem_addr      = pc_q;

  // Request only when the buffer can take the word and no redirect is replacing the PC
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      S_FETCH: imem_req = slotFree & ~redirect;
      S_WAIT:  imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Redirect takes priority; otherwise advance by one word on every accepted fetch
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirectTarget;
    end else if (capture) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // PC register; it only moves on capture or redirect, so it is frozen under backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Fetch controller: one idle cycle after reset, then park in WAIT while memory stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        S_FETCH: if (imem_req && !imem_ack) state_q <= S_WAIT;
        S_WAIT:  if (imem_ack) state_q <= S_FETCH;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  inst_buffer #(
    .XLEN       (XLEN),
    .INST_WIDTH (INST_WIDTH),
    .RESET_PC   (RESET_PC),
    .NOP_VALUE  (INST_WIDTH'(NOP_INST))
  ) u_inst_buffer (
    .clk          (clk),
    .reset        (reset),
    .capture_i    (capture),
    .consume_i    (consume),
    .inst_i       (imem_rdata),
    .pc_i         (pc_q),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (inst_valid)
  );

  // The buffer is always empty while waiting on memory, so a redirect there means a broken handshake
  noRedirectInWait: assert property (@(posedge clk) disable iff (reset)
    !(state_q == S_WAIT && redirect));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit.
module tb_inst_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        pc_sel;
  logic [31:0] alu_out;

  int totalChecks = 0;
  int badChecks   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc_sel     (pc_sel),
    .alu_out    (alu_out)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h0000_0008) return 32'h0050_0093;
    return addr ^ 32'h1357_0000;
  endfunction

  // Memory returns data combinationally for whatever address is presented
  always_comb imem_rdata = memWord(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic ready, input logic sel, input logic [31:0] alu);
    imem_ack   = ack;
    inst_ready = ready;
    pc_sel     = sel;
    alu_out    = alu;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle (pc = 0, buffer empty)
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_addr", imem_addr, 32'h0);

    // Release: IDLE cycle, then first request at 0
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t1_idle_req", 32'(imem_req), 32'd0);
    step();
    checkOutput("t1_first_req", 32'(imem_req), 32'd1);
    checkOutput("t1_first_addr", imem_addr, 32'h0);
    step();
    checkOutput("t1_wait_req", 32'(imem_req), 32'd1);
    checkOutput("t1_wait_addr", imem_addr, 32'h0);
    // Asynchronous reset in WAIT takes effect before the next edge
    reset = 1'b1;
    #1;
    checkOutput("t1_async_req", 32'(imem_req), 32'd0);
    checkOutput("t1_async_valid", 32'(inst_valid), 32'd0);
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_late_ack_req", 32'(imem_req), 32'd0);
    step();
    checkOutput("t1_late_ack_valid", 32'(inst_valid), 32'd0);
    checkOutput("t1_after_addr", imem_addr, 32'h0);

    // Zero-wait streaming
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_valid0", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t2_req", 32'(imem_req), 32'd1);
      checkOutput("t2_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        checkOutput("t2_valid", 32'(inst_valid), 32'd1);
        checkOutput("t2_inst_pc", inst_pc, 32'(4 * (k - 1)));
        checkOutput("t2_inst", inst, memWord(32'(4 * (k - 1))));
      end
      step();
    end

    // Three-cycle ack latency on address 0x4
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_addr_c1", imem_addr, 32'h4);
    checkOutput("t3_req_c1", 32'(imem_req), 32'd1);
    step();
    checkOutput("t3_addr_c2", imem_addr, 32'h4);
    checkOutput("t3_req_c2", 32'(imem_req), 32'd1);
    checkOutput("t3_valid_c2", 32'(inst_valid), 32'd0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_addr_c3", imem_addr, 32'h4);
    checkOutput("t3_valid_c3", 32'(inst_valid), 32'd0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_valid_after", 32'(inst_valid), 32'd1);
    checkOutput("t3_inst_pc", inst_pc, 32'h4);
    checkOutput("t3_next_addr", imem_addr, 32'h8);
    checkOutput("t3_next_req", 32'(imem_req), 32'd1);

    // Backpressure holding the instruction at 0x8
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    step();
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t4_valid", 32'(inst_valid), 32'd1);
      checkOutput("t4_inst", inst, 32'h0050_0093);
      checkOutput("t4_inst_pc", inst_pc, 32'h8);
      checkOutput("t4_req", 32'(imem_req), 32'd0);
      checkOutput("t4_addr", imem_addr, 32'hC);
      step();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_release_req", 32'(imem_req), 32'd1);
    checkOutput("t4_release_addr", imem_addr, 32'hC);

    // Redirect on consume of the instruction at 0x10
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    checkOutput("t5_inst_pc", inst_pc, 32'h10);
    checkOutput("t5_redirect_req", 32'(imem_req), 32'd0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_bubble_valid", 32'(inst_valid), 32'd0);
    checkOutput("t5_target_req", 32'(imem_req), 32'd1);
    checkOutput("t5_target_addr", imem_addr, 32'h100);
    step();
    checkOutput("t5_target_valid", 32'(inst_valid), 32'd1);
    checkOutput("t5_target_inst_pc", inst_pc, 32'h100);
    checkOutput("t5_target_inst", inst, memWord(32'h100));

    // PC wrap from the top word of the address space
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    checkOutput("t6_top_req", 32'(imem_req), 32'd1);
    step();
    checkOutput("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
    checkOutput("t6_wrap_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
